// File: rtl/ysyx_25030093_pc_pkg.sv
// Shared definitions for the program-counter generator:
//   next-PC select codes, FSM state encoding and default reset vector.
package ysyx_25030093_pc_pkg;

  // commit_sel encodings; 5-7 fall back to sequential
  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_JAL  = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_JALR = 3'd3;
  localparam logic [2:0] SEL_CSR  = 3'd4;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h3000_0000;

endpackage

// File: rtl/ysyx_25030093_pc_target.sv
// Combinational next-PC computation: adders, target mux and alignment check.
//   pc, sel, taken, len2, rs1, imm, csr_pc -> target, misaligned
module ysyx_25030093_pc_target
  import ysyx_25030093_pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned C_EXT = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      sel,
  input  logic            taken,
  input  logic            len2,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] csr_pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic            short_insn;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_sum;

  // the 16-bit length flag only matters when compressed instructions exist
  assign short_insn = (C_EXT != 0) && len2;
  assign seq_pc     = pc + (short_insn ? XLEN'(2) : XLEN'(4));
  assign rel_pc     = pc + imm;
  assign jalr_sum   = rs1 + imm;

  always_comb begin
    target = seq_pc;
    case (sel)
      SEL_JAL:  target = rel_pc;
      SEL_BR:   target = taken ? rel_pc : seq_pc;
      SEL_JALR: target = jalr_sum & ~XLEN'(1);
      SEL_CSR:  target = csr_pc & ~XLEN'(1);
      default:  target = seq_pc;
    endcase
  end

  // JALR/CSR clear bit 0, so with C_EXT they can never trip this
  assign misaligned = (C_EXT != 0) ? target[0] : target[1];

endmodule

// File: rtl/ysyx_25030093_pc_gen.sv
// Program-counter generator between the WBU and the IFU.
// Holds the PC, offers it to the IFU over valid/ready, updates it on WBU
// commit or external redirect, and pulses misalign_valid for bad targets.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   commit_*, rs1/imm/csr_pc     retire information from the WBU
//   redir_valid, redir_pc        interrupt/debug redirect, highest priority
//   pc, out_valid, out_ready     fetch handshake towards the IFU
//   misalign_valid/addr          misaligned-target report
//
// state    | meaning
// ST_BOOT  | just left reset, nothing offered yet
// ST_OFFER | pc offered to IFU, out_valid=1
// ST_WAIT  | pc accepted, waiting for the WBU to commit it
module ysyx_25030093_pc_gen
  import ysyx_25030093_pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int unsigned     C_EXT     = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [2:0]      commit_sel,
  input  logic            commit_taken,
  input  logic            commit_len2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] imm_data,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            misalign_valid,
  output logic [XLEN-1:0] misalign_addr
);

  logic [1:0]      state;
  logic [XLEN-1:0] target;
  logic            misaligned;

  ysyx_25030093_pc_target #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_target (
    .pc         (pc),
    .sel        (commit_sel),
    .taken      (commit_taken),
    .len2       (commit_len2),
    .rs1        (rs1_data),
    .imm        (imm_data),
    .csr_pc     (csr_pc),
    .target     (target),
    .misaligned (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_VEC;
      state          <= ST_BOOT;
      out_valid      <= 1'b0;
      misalign_valid <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      misalign_valid <= 1'b0;
      if (redir_valid) begin
        // redirect wins over any commit and withdraws a pending offer
        pc        <= redir_pc & ~XLEN'(1);
        state     <= ST_OFFER;
        out_valid <= 1'b1;
      end else begin
        case (state)
          ST_BOOT: begin
            state     <= ST_OFFER;
            out_valid <= 1'b1;
          end
          ST_OFFER: begin
            if (out_ready) begin
              state     <= ST_WAIT;
              out_valid <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (commit_valid) begin
              if (misaligned) begin
                misalign_valid <= 1'b1;
                misalign_addr  <= target;
              end else begin
                pc        <= target;
                state     <= ST_OFFER;
                out_valid <= 1'b1;
              end
            end
          end
          default: begin
            state     <= ST_BOOT;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // a commit while the pc is still on offer means the WBU ran ahead of fetch
  a_no_commit_in_offer: assert property (@(posedge clock) disable iff (reset)
    !(commit_valid && !redir_valid && state == ST_OFFER))
    else $error("commit_valid asserted while pc still offered");

endmodule

// File: tb/tb_ysyx_25030093_pc_gen.sv
module tb_ysyx_25030093_pc_gen;

  localparam logic [2:0] S_SEQ = 3'd0, S_JAL = 3'd1, S_BR = 3'd2, S_JALR = 3'd3, S_CSR = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [2:0]  commit_sel;
  logic        commit_taken;
  logic        commit_len2;
  logic [31:0] rs1_data, imm_data, csr_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic        misalign_valid;
  logic [31:0] misalign_addr;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ysyx_25030093_pc_gen dut (
    .clock          (clock),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_sel     (commit_sel),
    .commit_taken   (commit_taken),
    .commit_len2    (commit_len2),
    .rs1_data       (rs1_data),
    .imm_data       (imm_data),
    .csr_pc         (csr_pc),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .pc             (pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .misalign_valid (misalign_valid),
    .misalign_addr  (misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // IFU takes the offered pc: OFFER -> WAIT
  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("accept_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic commit(input logic [2:0] sel, input logic taken, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] csr);
    commit_valid = 1'b1;
    commit_sel   = sel;
    commit_taken = taken;
    rs1_data     = rs1;
    imm_data     = imm;
    csr_pc       = csr;
    step();
    commit_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; commit_valid = 1'b0; commit_sel = S_SEQ; commit_taken = 1'b0;
    commit_len2 = 1'b0; rs1_data = '0; imm_data = '0; csr_pc = '0;
    redir_valid = 1'b0; redir_pc = '0; out_ready = 1'b0;

    step();
    chk("rst_pc", pc, 32'h3000_0000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mis_v", {31'd0, misalign_valid}, 32'd0);
    chk("rst_mis_a", misalign_addr, 32'd0);
    reset = 1'b0;

    step();
    chk("boot_offer_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pc", pc, 32'h3000_0000);
    end

    accept();
    chk("wait_pc", pc, 32'h3000_0000);
    commit(S_SEQ, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("seq_pc", pc, 32'h3000_0004);
    chk("seq_valid", {31'd0, out_valid}, 32'd1);

    accept();
    commit(S_JALR, 1'b0, 32'h3000_0101, 32'd4, 32'd0);
    chk("jalr_pc", pc, 32'h3000_0104);

    accept();
    commit(S_JAL, 1'b0, 32'd0, 32'hFFFF_FF0C, 32'd0);
    chk("jal_back_pc", pc, 32'h3000_0010);

    accept();
    commit(S_BR, 1'b1, 32'd0, 32'hFFFF_FFF8, 32'd0);
    chk("br_taken_pc", pc, 32'h3000_0008);

    accept();
    commit(S_SEQ, 1'b0, 32'd0, 32'd0, 32'd0);
    accept();
    commit(S_SEQ, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("seq2_pc", pc, 32'h3000_0010);

    // odd imm on a not-taken branch must not raise misalign
    accept();
    commit(S_BR, 1'b0, 32'd0, 32'd3, 32'd0);
    chk("br_nt_pc", pc, 32'h3000_0014);
    chk("br_nt_mis", {31'd0, misalign_valid}, 32'd0);

    accept();
    commit(S_JAL, 1'b0, 32'd0, 32'hFFFF_FFEC, 32'd0);
    chk("jal_home_pc", pc, 32'h3000_0000);

    accept();
    commit(S_JAL, 1'b0, 32'd0, 32'd6, 32'd0);
    chk("mis_pulse", {31'd0, misalign_valid}, 32'd1);
    chk("mis_addr", misalign_addr, 32'h3000_0006);
    chk("mis_pc_kept", pc, 32'h3000_0000);
    chk("mis_no_offer", {31'd0, out_valid}, 32'd0);
    step();
    chk("mis_pulse_end", {31'd0, misalign_valid}, 32'd0);
    chk("mis_addr_held", misalign_addr, 32'h3000_0006);
    commit(S_CSR, 1'b0, 32'd0, 32'd0, 32'h3000_0100);
    chk("csr_pc", pc, 32'h3000_0100);
    chk("csr_valid", {31'd0, out_valid}, 32'd1);

    // redirect in OFFER with ready and commit in the same cycle
    out_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h8000_0003;
    commit_valid = 1'b1; commit_sel = S_SEQ;
    step();
    out_ready = 1'b0; redir_valid = 1'b0; commit_valid = 1'b0;
    chk("redir_pc", pc, 32'h8000_0002);
    chk("redir_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_no_mis", {31'd0, misalign_valid}, 32'd0);
    step();
    chk("redir_still_offer", {31'd0, out_valid}, 32'd1);
    chk("redir_pc_stable", pc, 32'h8000_0002);

    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step();
    redir_valid = 1'b0;
    chk("redir2_pc", pc, 32'hFFFF_FFFC);
    accept();
    commit(S_SEQ, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("wrap_pc", pc, 32'h0000_0000);

    // reset mid-WAIT with a misaligning commit pending
    accept();
    reset = 1'b1; commit_valid = 1'b1; commit_sel = S_JAL; imm_data = 32'd6;
    step();
    reset = 1'b0; commit_valid = 1'b0;
    chk("rst2_pc", pc, 32'h3000_0000);
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_mis_v", {31'd0, misalign_valid}, 32'd0);
    chk("rst2_mis_a", misalign_addr, 32'd0);
    step();
    chk("rst2_offer", {31'd0, out_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
